// File: rtl/sys_tick_gen_if.sv
// Control and status bundle between the system top and the tick/reset sequencer.
interface sys_tick_gen_if #(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 16
);
  logic [NUM_CH*DIV_W-1:0] div_i;
  logic [NUM_CH-1:0]       en_i;
  logic                    sync_i;
  logic                    sys_rst_n_o;
  logic [NUM_CH-1:0]       tick_o;

  modport master (output div_i, en_i, sync_i, input sys_rst_n_o, tick_o);
  modport slave  (input div_i, en_i, sync_i, output sys_rst_n_o, tick_o);
endinterface

// File: rtl/sys_tick_gen.sv
// Stretches rst into a fixed-length active-low system reset, then generates
// NUM_CH independent divided tick strobes with runtime divisors, enables and sync.
//   state | meaning
//   HOLD  | system reset asserted, hold counter running, channels frozen
//   RUN   | system reset released, channels counting (left only by rst)
module sys_tick_gen #(
  parameter int NUM_CH   = 2,
  parameter int DIV_W    = 16,
  parameter int RST_HOLD = 16
) (
  input  logic          clk,
  input  logic          rst,
  sys_tick_gen_if.slave bus
);

  localparam int HW = $clog2(RST_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);

  typedef enum logic {HOLD, RUN} state_t;

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic          sys_rst_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HOLD;
      hold_cnt  <= '0;
      sys_rst_n <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (hold_cnt == HOLD_LAST) begin
            state     <= RUN;
            sys_rst_n <= 1'b1;
          end
        end
        RUN: begin
          sys_rst_n <= 1'b1;
        end
        default: begin
          state     <= HOLD;
          sys_rst_n <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sys_rst_n_o = sys_rst_n;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div;
    logic             tick;

    assign div = bus.div_i[k*DIV_W +: DIV_W];

    // ">=" lets a shrinking divisor wrap immediately instead of running through 2^DIV_W
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt  <= '0;
        tick <= 1'b0;
      end else if (state != RUN || !bus.en_i[k] || bus.sync_i) begin
        cnt  <= '0;
        tick <= 1'b0;
      end else if (cnt >= div) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + 1'b1;
        tick <= 1'b0;
      end
    end

    assign bus.tick_o[k] = tick;
  end

endmodule

// File: tb/tb_sys_tick_gen.sv
// Directed bench for sys_tick_gen: reset stretch, tick periods, enable, divisor change, sync, async reset.
module tb_sys_tick_gen;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  sys_tick_gen_if #(.NUM_CH(2), .DIV_W(16)) bus ();

  sys_tick_gen #(.NUM_CH(2), .DIV_W(16), .RST_HOLD(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] en;
    logic       sync;
    logic       exp_rstn;
    logic [1:0] exp_tick;
  } vec_t;

  vec_t vec [28];

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_tick0(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.tick_o[0] && n < 100);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;

    for (int i = 0; i < 16; i++) vec[i] = '{2'b11, 1'b0, (i == 15), 2'b00};
    // RUN edges r1..r12: ch0 div=3, ch1 div=0, ch1 enable dropped for r6 only
    vec[16] = '{2'b11, 1'b0, 1'b1, 2'b10};
    vec[17] = '{2'b11, 1'b0, 1'b1, 2'b10};
    vec[18] = '{2'b11, 1'b0, 1'b1, 2'b10};
    vec[19] = '{2'b11, 1'b0, 1'b1, 2'b11};
    vec[20] = '{2'b11, 1'b0, 1'b1, 2'b10};
    vec[21] = '{2'b01, 1'b0, 1'b1, 2'b00};
    vec[22] = '{2'b11, 1'b0, 1'b1, 2'b10};
    vec[23] = '{2'b11, 1'b0, 1'b1, 2'b11};
    vec[24] = '{2'b11, 1'b0, 1'b1, 2'b10};
    vec[25] = '{2'b11, 1'b0, 1'b1, 2'b10};
    vec[26] = '{2'b11, 1'b0, 1'b1, 2'b10};
    vec[27] = '{2'b11, 1'b0, 1'b1, 2'b11};

    rst = 1'b1;
    bus.div_i  = {16'd0, 16'd3};
    bus.en_i   = 2'b11;
    bus.sync_i = 1'b0;

    for (int i = 0; i < 5; i++) begin
      step();
      check("reset_rstn", bus.sys_rst_n_o, 0);
      check("reset_tick", bus.tick_o, 0);
    end
    rst = 1'b0;

    for (int i = 0; i < 28; i++) begin
      bus.en_i   = vec[i].en;
      bus.sync_i = vec[i].sync;
      step();
      check($sformatf("vec%0d_rstn", i), bus.sys_rst_n_o, vec[i].exp_rstn);
      check($sformatf("vec%0d_tick", i), bus.tick_o, vec[i].exp_tick);
    end

    for (int p = 0; p < 10; p++) begin
      wait_tick0(n);
      check($sformatf("ch0_period%0d", p), n, 4);
    end

    // divisor change mid-count
    bus.div_i[15:0] = 16'd9;
    bus.sync_i = 1'b1;
    step();
    bus.sync_i = 1'b0;
    check("div_sync_edge", bus.tick_o[0], 0);
    for (int j = 1; j <= 6; j++) begin
      step();
      check($sformatf("div9_cnt%0d", j), bus.tick_o[0], 0);
    end
    bus.div_i[15:0] = 16'd4;
    step();
    check("div_shrink_tick", bus.tick_o[0], 1);
    wait_tick0(n);
    check("div4_period", n, 5);
    step();
    step();
    check("div4_cnt2", bus.tick_o[0], 0);
    bus.div_i[15:0] = 16'd20;
    wait_tick0(n);
    check("div_grow_gap", n, 19);

    // sync at ch0 terminal count
    bus.div_i  = {16'd5, 16'd3};
    bus.sync_i = 1'b1;
    step();
    bus.sync_i = 1'b0;
    check("sync_align", bus.tick_o, 0);
    for (int j = 1; j <= 3; j++) begin
      step();
      check($sformatf("sync_pre%0d", j), bus.tick_o, 0);
    end
    bus.sync_i = 1'b1;
    step();
    bus.sync_i = 1'b0;
    check("sync_over_tc", bus.tick_o, 0);
    for (int j = 1; j <= 24; j++) begin
      step();
      check($sformatf("sync_run%0d", j), bus.tick_o, {(j % 6 == 0), (j % 4 == 0)});
    end

    // asynchronous reset mid-cycle
    bus.div_i[31:16] = 16'd0;
    step();
    check("pre_reset_tick1", bus.tick_o[1], 1);
    #4;
    rst = 1'b1;
    #1;
    check("async_rstn", bus.sys_rst_n_o, 0);
    check("async_tick", bus.tick_o, 0);
    for (int i = 0; i < 3; i++) step();
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      check($sformatf("rehold%0d_rstn", i), bus.sys_rst_n_o, (i == 16));
      check($sformatf("rehold%0d_tick", i), bus.tick_o, 0);
    end
    step();
    check("rerun_first_tick", bus.tick_o, 2'b10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
